// File: rtl/bnn_class_argmax_if.sv
`default_nettype none
// ============================================================================
// bnn_class_argmax_if : frame control, score stream and result bus | Rev 1.0
// ============================================================================
interface bnn_class_argmax_if #(
  parameter int IL = 11,
  parameter int CW = 3
);
  logic          iCLR;
  logic          iSTART;
  logic          iEN;
  logic [IL-1:0] iDATA;
  logic          oBUSY;
  logic          oDONE;
  logic [CW-1:0] oCLASS;
  logic [IL-1:0] oSCORE;
  logic          oERR;
  logic [IL-1:0] oMARGIN;

  modport master (
    output iCLR, iSTART, iEN, iDATA,
    input  oBUSY, oDONE, oCLASS, oSCORE, oERR, oMARGIN
  );

  modport slave (
    input  iCLR, iSTART, iEN, iDATA,
    output oBUSY, oDONE, oCLASS, oSCORE, oERR, oMARGIN
  );
endinterface
`default_nettype wire

// File: rtl/bnn_class_argmax.sv
`default_nettype none
// ============================================================================
// bnn_class_argmax : registered argmax over NCLS unsigned class scores/frame.
// BNN_ARGMAX_MARGIN_EN adds runner-up tracking for oMARGIN. | Rev 1.0
// ============================================================================
module bnn_class_argmax #(
  parameter int NCLS = 8,
  parameter int IL   = 11,
  parameter int CW   = 3
) (
  input wire                iCLK,
  input wire                iRSTn,
  bnn_class_argmax_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(NCLS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IL-1:0] best_q, best_d;
  logic [CW-1:0] class_q, class_d;
  logic          err_q, err_d;
`ifdef BNN_ARGMAX_MARGIN_EN
  logic [IL-1:0] second_q, second_d;
  logic [IL-1:0] margin_q, margin_d;
`endif

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      best_q   <= '0;
      class_q  <= '0;
      err_q    <= 1'b0;
`ifdef BNN_ARGMAX_MARGIN_EN
      second_q <= '0;
      margin_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      best_q   <= best_d;
      class_q  <= class_d;
      err_q    <= err_d;
`ifdef BNN_ARGMAX_MARGIN_EN
      second_q <= second_d;
      margin_q <= margin_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    best_d   = best_q;
    class_d  = class_q;
    err_d    = err_q;
`ifdef BNN_ARGMAX_MARGIN_EN
    second_d = second_q;
`endif
    if (bus.iCLR) begin
      state_d  = IDLE;
      cnt_d    = '0;
      best_d   = '0;
      class_d  = '0;
      err_d    = 1'b0;
`ifdef BNN_ARGMAX_MARGIN_EN
      second_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.iSTART) begin
            state_d  = COLLECT;
            cnt_d    = '0;
            best_d   = '0;
            class_d  = '0;
            err_d    = 1'b0;
`ifdef BNN_ARGMAX_MARGIN_EN
            second_d = '0;
`endif
          end
          // A stray score is an error even on the start cycle; set beats clear.
          if (bus.iEN) err_d = 1'b1;
        end
        COLLECT: begin
          if (bus.iEN) begin
            if (cnt_q == '0) begin
              best_d   = bus.iDATA;
              class_d  = '0;
`ifdef BNN_ARGMAX_MARGIN_EN
              second_d = '0;
`endif
            end else if (bus.iDATA > best_q) begin
`ifdef BNN_ARGMAX_MARGIN_EN
              second_d = best_q;
`endif
              best_d   = bus.iDATA;
              class_d  = cnt_q;
            end
`ifdef BNN_ARGMAX_MARGIN_EN
            else if (bus.iDATA > second_q) begin
              second_d = bus.iDATA;
            end
`endif
            if (cnt_q == LAST) state_d = DONE;
            else               cnt_d   = cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
          if (bus.iEN) err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef BNN_ARGMAX_MARGIN_EN
    margin_d = best_d - second_d;
`endif
  end

  assign bus.oBUSY  = (state_q == COLLECT);
  assign bus.oDONE  = (state_q == DONE);
  assign bus.oCLASS = class_q;
  assign bus.oSCORE = best_q;
  assign bus.oERR   = err_q;
`ifdef BNN_ARGMAX_MARGIN_EN
  assign bus.oMARGIN = margin_q;
`else
  assign bus.oMARGIN = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bnn_class_argmax.sv
`default_nettype none
// ============================================================================
// tb_bnn_class_argmax : directed bench for bnn_class_argmax | Rev 1.0
// ============================================================================
module tb_bnn_class_argmax;

`ifdef BNN_ARGMAX_MARGIN_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic iCLK  = 1'b0;
  logic iRSTn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  bnn_class_argmax_if #(.IL(11), .CW(3)) bus ();

  bnn_class_argmax #(.NCLS(8), .IL(11), .CW(3)) dut (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .bus   (bus.slave)
  );

  always #5 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic done, input int cls,
                         input int score, input int margin);
    chk({tag, "_done"},   32'(bus.oDONE),   32'(done));
    chk({tag, "_class"},  32'(bus.oCLASS),  cls);
    chk({tag, "_score"},  32'(bus.oSCORE),  score);
    chk({tag, "_margin"}, 32'(bus.oMARGIN), MEN ? margin : 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.oBUSY), 0);
    chk({tag, "_err"},  32'(bus.oERR),  0);
    chk_res(tag, 1'b0, 0, 0, 0);
  endtask

  task automatic start();
    bus.iSTART = 1'b1;
    step();
    bus.iSTART = 1'b0;
  endtask

  task automatic send(input int score);
    bus.iEN   = 1'b1;
    bus.iDATA = 11'(score);
    step();
    bus.iEN   = 1'b0;
  endtask

  int f1 [8] = '{5, 9, 3, 12, 7, 1, 0, 2};
  int f2 [8] = '{4, 10, 10, 2, 10, 0, 0, 0};
  int g2 [8] = '{0, 1, 2, 3, 0, 3, 1, 2};

  initial begin
    bus.iCLR = 1'b0; bus.iSTART = 1'b0; bus.iEN = 1'b0; bus.iDATA = '0;
    step(); step();
    chk_zero("reset");
    #2 iRSTn = 1'b1;
    step();
    chk_zero("post_reset");

    // Frame 1: consecutive scores
    start();
    chk("f1_busy", 32'(bus.oBUSY), 1);
    for (int i = 0; i < 8; i++) send(f1[i]);
    chk("f1_busy_done", 32'(bus.oBUSY), 0);
    chk_res("f1", 1'b1, 3, 12, 3);
    step();
    chk_res("f1_hold", 1'b0, 3, 12, 3);

    // Frame 2: ties with iEN gaps
    start();
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < g2[i]; g++) begin
        chk("f2_gap_busy", 32'(bus.oBUSY), 1);
        step();
      end
      chk("f2_busy", 32'(bus.oBUSY), 1);
      send(f2[i]);
    end
    chk_res("f2", 1'b1, 1, 10, 0);
    step();

    // Frame 3: full-scale scores
    start();
    for (int i = 0; i < 8; i++) send(2047);
    chk_res("f3", 1'b1, 0, 2047, 0);
    step();

    // Stray score in IDLE
    send(100);
    chk("idle_err", 32'(bus.oERR), 1);
    chk_res("idle_hold", 1'b0, 0, 2047, 0);
    step();
    chk("idle_err_held", 32'(bus.oERR), 1);

    // Next start clears the error; then a 9th score in DONE
    start();
    chk("start_clr_err", 32'(bus.oERR), 0);
    chk_res("start_clr_res", 1'b0, 0, 0, 0);
    for (int i = 0; i < 8; i++) send(f1[i]);
    chk_res("f4", 1'b1, 3, 12, 3);
    bus.iEN = 1'b1; bus.iDATA = 11'd2000;
    step();
    bus.iEN = 1'b0;
    chk("done_err", 32'(bus.oERR), 1);
    chk_res("done_discard", 1'b0, 3, 12, 3);

    // iCLR mid-frame
    start();
    for (int i = 0; i < 4; i++) send(f1[i]);
    bus.iCLR = 1'b1; bus.iSTART = 1'b1; bus.iEN = 1'b1; bus.iDATA = 11'd50;
    step();
    bus.iCLR = 1'b0; bus.iSTART = 1'b0; bus.iEN = 1'b0;
    chk_zero("clr");
    step();
    chk_zero("clr_nodone");

    // Winner in the last slot
    start();
    for (int i = 0; i < 7; i++) send(0);
    send(1);
    chk_res("f5", 1'b1, 7, 1, 1);
    step();

    // Asynchronous reset mid-frame
    start();
    send(20); send(30); send(25);
    #2 iRSTn = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.oBUSY), 0);
    chk_res("arst", 1'b0, 0, 0, 0);
    step();
    #2 iRSTn = 1'b1;
    step();
    chk_zero("arst_rel");

    // iSTART held across two frames
    bus.iSTART = 1'b1;
    step();
    chk("hold_busy1", 32'(bus.oBUSY), 1);
    for (int i = 0; i < 8; i++) send(f1[i]);
    chk_res("hold_f1", 1'b1, 3, 12, 3);
    step();
    chk("hold_idle", 32'(bus.oBUSY), 0);
    chk("hold_idle_done", 32'(bus.oDONE), 0);
    step();
    chk("hold_busy2", 32'(bus.oBUSY), 1);
    bus.iSTART = 1'b0;
    for (int i = 0; i < 8; i++) send(i + 1);
    chk_res("hold_f2", 1'b1, 7, 8, 1);
    chk("hold_err", 32'(bus.oERR), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
